// File: rtl/ram_sdp_2048x64_access_arbiter.sv
// Purpose     : shares one 2048x64 SDP RAM between a write client and two round-robin read clients.
// Latency     : grants are combinational; rdN_rvalid/rd_rdata arrive two non-write cycles after the grant.
// Backpressure: clients hold req until gnt; one slot per cycle, writes yield after WR_BURST_MAX while a read waits.
//
// Ports:
//   clk_i, rst_n_i                   clock, synchronous active-low reset
//   wr_req_i/wr_addr_i/wr_data_i     write client request, address, data; wr_gnt_o accepts
//   rdN_req_i/rdN_addr_i (N=0,1)     read client request and address; rdN_gnt_o accepts
//   rdN_rvalid_o, rd_rdata_o         one-cycle read-return pulse per client, shared return data
//   ram_we_o/ram_write_addr_o/ram_din_o/ram_read_addr_o/ram_dout_i   RAM side
module ram_sdp_2048x64_access_arbiter #(
  parameter int ADDR_W       = 11,
  parameter int DATA_W       = 64,
  parameter int WR_BURST_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              wr_req_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_gnt_o,
  input  logic              rd0_req_i,
  input  logic [ADDR_W-1:0] rd0_addr_i,
  output logic              rd0_gnt_o,
  output logic              rd0_rvalid_o,
  input  logic              rd1_req_i,
  input  logic [ADDR_W-1:0] rd1_addr_i,
  output logic              rd1_gnt_o,
  output logic              rd1_rvalid_o,
  output logic [DATA_W-1:0] rd_rdata_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_write_addr_o,
  output logic [DATA_W-1:0] ram_din_o,
  output logic [ADDR_W-1:0] ram_read_addr_o,
  input  logic [DATA_W-1:0] ram_dout_i
);

  localparam int              RUN_W   = $clog2(WR_BURST_MAX + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(WR_BURST_MAX);

  // One in-flight read: valid flag plus the issuing client (0 = rd0, 1 = rd1).
  typedef struct packed {
    logic vld;
    logic id;
  } tag_t;

  logic [RUN_W-1:0]  wr_run_q, wr_run_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  tag_t              s1_q, s1_d;
  tag_t              s2_q, s2_d;
  logic              adv_q, adv_d;

  logic              rd_pend;
  logic              rd_force;
  logic              wr_gnt;
  logic              rd_gnt_any;
  logic              gnt_id;
  logic [ADDR_W-1:0] rd_addr_sel;

  // Slot arbitration: write first, unless the burst budget is spent and a reader waits.
  always_comb begin
    rd_pend     = rd0_req_i | rd1_req_i;
    rd_force    = rd_pend & (wr_run_q == RUN_MAX);
    wr_gnt      = rst_n_i & wr_req_i & ~rd_force;
    rd_gnt_any  = rst_n_i & rd_pend & ~wr_gnt;
    // Sole requester wins outright; rr_ptr only breaks ties.
    gnt_id      = (rd0_req_i & rd1_req_i) ? rr_ptr_q : rd1_req_i;
    rd_addr_sel = gnt_id ? rd1_addr_i : rd0_addr_i;
  end

  always_comb begin
    wr_run_d = wr_run_q;
    rr_ptr_d = rr_ptr_q;
    raddr_d  = raddr_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    adv_d    = ~wr_gnt;

    if (rd_gnt_any || !rd_pend) begin
      wr_run_d = '0;
    end else if (wr_gnt && (wr_run_q != RUN_MAX)) begin
      wr_run_d = wr_run_q + RUN_W'(1);
    end

    if (rd_gnt_any) begin
      rr_ptr_d = ~gnt_id;
      raddr_d  = rd_addr_sel;
    end

    // The RAM read stages only move on non-write edges; the tags follow them exactly.
    if (!wr_gnt) begin
      s1_d.vld = rd_gnt_any;
      s1_d.id  = gnt_id & rd_gnt_any;
      s2_d     = s1_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_run_q <= '0;
      rr_ptr_q <= 1'b0;
      raddr_q  <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      adv_q    <= 1'b0;
    end else begin
      wr_run_q <= wr_run_d;
      rr_ptr_q <= rr_ptr_d;
      raddr_q  <= raddr_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      adv_q    <= adv_d;
    end
  end

  // s2 is loaded from s1 only on advancing edges, so gating with adv_q gives a single
  // registered pulse per read that is cleared on any stalled edge.
  assign rd0_rvalid_o     = adv_q & s2_q.vld & ~s2_q.id;
  assign rd1_rvalid_o     = adv_q & s2_q.vld &  s2_q.id;
  assign rd_rdata_o       = ram_dout_i;

  assign wr_gnt_o         = wr_gnt;
  assign rd0_gnt_o        = rd_gnt_any & ~gnt_id;
  assign rd1_gnt_o        = rd_gnt_any &  gnt_id;

  assign ram_we_o         = wr_gnt;
  assign ram_write_addr_o = wr_addr_i;
  assign ram_din_o        = wr_data_i;
  // Granted address goes straight to the RAM this cycle; otherwise the last one is held.
  assign ram_read_addr_o  = raddr_d;

endmodule

// File: tb/tb_ram_sdp_2048x64_access_arbiter.sv
module tb_ram_sdp_2048x64_access_arbiter;

  localparam int AW = 11;
  localparam int DW = 64;
  localparam int BM = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          wr_req, wr_gnt;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd0_req, rd0_gnt, rd0_rvalid;
  logic          rd1_req, rd1_gnt, rd1_rvalid;
  logic [AW-1:0] rd0_addr, rd1_addr;
  logic [DW-1:0] rd_rdata;
  logic          ram_we;
  logic [AW-1:0] ram_write_addr, ram_read_addr;
  logic [DW-1:0] ram_din, ram_dout;

  ram_sdp_2048x64_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WR_BURST_MAX(BM)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_gnt_o(wr_gnt),
    .rd0_req_i(rd0_req), .rd0_addr_i(rd0_addr), .rd0_gnt_o(rd0_gnt), .rd0_rvalid_o(rd0_rvalid),
    .rd1_req_i(rd1_req), .rd1_addr_i(rd1_addr), .rd1_gnt_o(rd1_gnt), .rd1_rvalid_o(rd1_rvalid),
    .rd_rdata_o(rd_rdata),
    .ram_we_o(ram_we), .ram_write_addr_o(ram_write_addr), .ram_din_o(ram_din),
    .ram_read_addr_o(ram_read_addr), .ram_dout_i(ram_dout)
  );

  // RAM: array read into stage 1, stage 2 drives dout; both stages stall while we=1.
  logic [DW-1:0] ram_mem [0:2047];
  logic [DW-1:0] ram_st1;
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_write_addr] <= ram_din;
    else begin
      ram_st1  <= ram_mem[ram_read_addr];
      ram_dout <= ram_st1;
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: memory contents, burst counter, tie-break pointer, outstanding reads.
  typedef struct {
    int            id;
    logic [DW-1:0] data;
    int            advs;   // non-write edges seen since grant; returns after two
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] m_mem [0:2047];
  int            m_run = 0;
  int            m_rr  = 0;
  bit            mon_en = 0;
  bit            g_wr, g_rd0, g_rd1;
  int            rv_cycle [2];
  int            rv_cnt   [2];
  logic [DW-1:0] rv_data  [2];

  // Monitor: response checking against the scoreboard, then grant prediction and model update.
  always @(negedge clk) begin : mon
    int            rid;
    int            pid;
    bit            any_rd, pw, p_rd;
    logic [AW-1:0] paddr;
    exp_t          e;
    if (mon_en) begin
      g_wr = wr_gnt; g_rd0 = rd0_gnt; g_rd1 = rd1_gnt;

      if (rd0_rvalid || rd1_rvalid) begin
        rid = rd1_rvalid ? 1 : 0;
        chk("rvalid_onehot", rd0_rvalid & rd1_rvalid, 0);
        rv_cnt[rid]++;
        rv_cycle[rid] = cyc;
        rv_data[rid]  = rd_rdata;
        if (sb.size() == 0) chk("rvalid_unexpected_qdepth", sb.size(), 1);
        else begin
          e = sb.pop_front();
          chk("rv_id", rid, e.id);
          chk("rv_data", rd_rdata, e.data);
          chk("rv_latency", e.advs, 2);
        end
      end else if (sb.size() > 0 && sb[0].advs >= 2) begin
        chk("rv_missing", 0, 1);
        void'(sb.pop_front());
      end

      any_rd = rd0_req || rd1_req;
      pw     = rst_n && wr_req && !(m_run == BM && any_rd);
      p_rd   = rst_n && any_rd && !pw;
      pid    = (rd0_req && rd1_req) ? m_rr : (rd1_req ? 1 : 0);
      paddr  = (pid == 1) ? rd1_addr : rd0_addr;

      chk("grants{wr,we,rd0,rd1}", {wr_gnt, ram_we, rd0_gnt, rd1_gnt},
          {pw, pw, p_rd && pid == 0, p_rd && pid == 1});
      if (p_rd) chk("ram_read_addr", ram_read_addr, paddr);
      if (pw)   chk("ram_write_port", {ram_write_addr, ram_din}, {wr_addr, wr_data});

      if (!rst_n) begin
        sb.delete();
        m_run = 0;
        m_rr  = 0;
      end else begin
        if (p_rd) begin
          e.id = pid; e.data = m_mem[paddr]; e.advs = 0;
          sb.push_back(e);
          m_run = 0;
          m_rr  = 1 - pid;
        end else if (!any_rd) m_run = 0;
        else if (pw && m_run < BM) m_run++;
        if (pw) m_mem[wr_addr] = wr_data;
        else for (int i = 0; i < sb.size(); i++) sb[i].advs = sb[i].advs + 1;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // which: 0 = write, 1 = rd0, 2 = rd1. Returns at posedge+1 after the grant cycle.
  task automatic wait_gnt(input int which, output int gc);
    bit got = 0;
    gc = -100;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if ((which == 0 && wr_gnt) || (which == 1 && rd0_gnt) || (which == 2 && rd1_gnt)) begin
        got = 1;
        gc  = cyc;
      end
    end
    chk("grant_within_budget", got, 1);
    @(posedge clk); #1;
  endtask

  task automatic do_wr(input int a, input logic [DW-1:0] d);
    int gc;
    wr_req = 1; wr_addr = AW'(a); wr_data = d;
    wait_gnt(0, gc);
    wr_req = 0;
  endtask

  task automatic do_rd(input int id, input int a, output int gc);
    if (id == 0) begin rd0_req = 1; rd0_addr = AW'(a); end
    else         begin rd1_req = 1; rd1_addr = AW'(a); end
    wait_gnt(id + 1, gc);
    rd0_req = 0; rd1_req = 0;
  endtask

  task automatic do_reset();
    rst_n = 0; step(); rst_n = 1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  localparam logic [DW-1:0] D_T1  = 64'h0123_4567_89AB_CDEF;
  localparam logic [DW-1:0] D_A10 = 64'hAAAA_0000_0000_0010;
  localparam logic [DW-1:0] D_A20 = 64'hBBBB_0000_0000_0020;
  localparam logic [DW-1:0] D_OLD = 64'hDEAD_BEEF_0000_0007;
  localparam logic [DW-1:0] D_NEW = 64'hCAFE_F00D_1234_0007;

  initial begin
    int gc, n, n1, c0, c1;
    for (int i = 0; i < 2048; i++) begin
      ram_mem[i] = '0;
      m_mem[i]   = '0;
    end
    ram_st1 = '0; ram_dout = '0;
    rv_cycle[0] = 0; rv_cycle[1] = 0; rv_cnt[0] = 0; rv_cnt[1] = 0;
    rv_data[0] = '0; rv_data[1] = '0;

    // Reset with requests pending: nothing may be granted, outputs idle.
    rst_n = 0; wr_req = 1; wr_addr = 3; wr_data = 64'h55;
    rd0_req = 1; rd0_addr = 9; rd1_req = 0; rd1_addr = 0;
    step(); step();
    chk("reset_grants", {wr_gnt, ram_we, rd0_gnt, rd1_gnt}, 4'b0000);
    chk("reset_rvalid", {rd0_rvalid, rd1_rvalid}, 2'b00);
    chk("reset_read_addr", ram_read_addr, 0);
    wr_req = 0; rd0_req = 0; rst_n = 1;
    mon_en = 1;
    step();

    // 1: write then read on rd0, two-cycle latency, rd1 stays quiet.
    do_wr(5, D_T1);
    n1 = rv_cnt[1];
    do_rd(0, 5, gc);
    repeat (4) step();
    chk("t1_latency", rv_cycle[0] - gc, 2);
    chk("t1_data", rv_data[0], D_T1);
    chk("t1_rd1_quiet", rv_cnt[1], n1);

    // 2: both readers continuously after reset alternate, rd0 first.
    do_wr(10, D_A10);
    do_wr(20, D_A20);
    do_reset();
    c0 = rv_cnt[0]; c1 = rv_cnt[1];
    rd0_req = 1; rd0_addr = 10; rd1_req = 1; rd1_addr = 20;
    @(negedge clk);
    chk("t2_rd0_first", {rd0_gnt, rd1_gnt}, 2'b10);
    @(posedge clk); #1;
    repeat (9) step();
    rd0_req = 0; rd1_req = 0;
    repeat (4) step();
    chk("t2_rd0_returns", rv_cnt[0] - c0, 5);
    chk("t2_rd1_returns", rv_cnt[1] - c1, 5);
    chk("t2_last_rd1_data", rv_data[1], D_A20);

    // 3: write pressure with rd1 pending: reads still get through every BM writes.
    rd1_req = 1; rd1_addr = 20; wr_req = 1; n = 0;
    for (int k = 0; k < 12; k++) begin
      wr_addr = AW'($urandom_range(32, 47));
      wr_data = {$urandom, $urandom};
      @(negedge clk);
      if (rd1_gnt) n++;
      @(posedge clk); #1;
    end
    wr_req = 0; rd1_req = 0;
    chk("t3_reads_under_pressure", n, 2);
    repeat (4) step();

    // 4: a write right after the read grant adds one cycle of latency.
    c0 = rv_cnt[0];
    do_rd(0, 10, gc);
    do_wr(30, 64'h3030);
    repeat (5) step();
    chk("t4_latency", rv_cycle[0] - gc, 3);
    chk("t4_single_pulse", rv_cnt[0] - c0, 1);
    chk("t4_data", rv_data[0], D_A10);

    // 5: read immediately after a write to the same address sees the new data.
    do_wr(7, D_OLD);
    do_wr(7, D_NEW);
    do_rd(0, 7, gc);
    repeat (4) step();
    chk("t5_read_after_write", rv_data[0], D_NEW);

    // 6: reset with reads in flight drops them and restores rd0 preference.
    do_reset();
    rd0_req = 1; rd0_addr = 10; rd1_req = 1; rd1_addr = 20;
    step(); step(); step();
    rst_n = 0; wr_req = 1; wr_addr = 1; wr_data = 64'h1;
    step();
    rst_n = 1; wr_req = 0; rd0_req = 0; rd1_req = 0;
    n = rv_cnt[0] + rv_cnt[1];
    repeat (5) step();
    chk("t6_no_rvalid_after_reset", rv_cnt[0] + rv_cnt[1], n);
    rd0_req = 1; rd1_req = 1;
    @(negedge clk);
    chk("t6_rd0_first_after_reset", {rd0_gnt, rd1_gnt}, 2'b10);
    @(posedge clk); #1;
    rd0_req = 0; rd1_req = 0;
    repeat (4) step();

    // Random traffic: clients hold requests until granted, occasionally withdraw, rare resets.
    for (int c = 0; c < 400; c++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      if (!wr_req || g_wr) begin
        wr_req  = ($urandom_range(0, 99) < 50);
        wr_addr = AW'($urandom_range(0, 15));
        wr_data = {$urandom, $urandom};
      end else if ($urandom_range(0, 15) == 0) wr_req = 0;
      if (!rd0_req || g_rd0) begin
        rd0_req  = ($urandom_range(0, 99) < 40);
        rd0_addr = AW'($urandom_range(0, 15));
      end else if ($urandom_range(0, 15) == 0) rd0_req = 0;
      if (!rd1_req || g_rd1) begin
        rd1_req  = ($urandom_range(0, 99) < 40);
        rd1_addr = AW'($urandom_range(0, 15));
      end else if ($urandom_range(0, 15) == 0) rd1_req = 0;
      step();
    end
    rst_n = 1; wr_req = 0; rd0_req = 0; rd1_req = 0;
    repeat (8) step();
    chk("drain_outstanding", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
